// File: rtl/status_line_formatter.sv
// Turns the launch velocity and angle into a 32-character ASCII status line.
// Each value goes through a sequential shift-add-3 binary-to-BCD conversion, one bit per clock.
module status_line_formatter #(
  parameter logic [7:0] PAD_CHAR = 8'h20,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [31:0]  velocity,
  input  logic [31:0]  angle,
  output logic [255:0] output_line,
  output logic         line_valid,
  output logic         busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CONV_V   = 2'd1;
  localparam logic [1:0] CONV_A   = 2'd2;
  localparam logic [1:0] ASSEMBLE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  bit_cnt;
  logic [16:0] vel_bin;
  logic [19:0] vel_bcd;
  logic [9:0]  ang_bin;
  logic [11:0] ang_bcd;
  logic [19:0] vel_adj;
  logic [11:0] ang_adj;

  function automatic logic [16:0] sat_vel(input logic [31:0] v);
    return (v > 32'd99999) ? 17'd99999 : v[16:0];
  endfunction

  function automatic logic [9:0] sat_ang(input logic [31:0] a);
    return (a > 32'd999) ? 10'd999 : a[9:0];
  endfunction

  function automatic logic [19:0] add3_vel(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [11:0] add3_ang(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [255:0] build_line(input logic [19:0] v, input logic [11:0] a);
    logic [255:0] l;
    l[255:120] = {8'h56, 8'h45, 8'h4C, SEP_CHAR,
                  dig(v[19:16]), dig(v[15:12]), dig(v[11:8]), dig(v[7:4]), dig(v[3:0]),
                  SEP_CHAR, 8'h41, 8'h4E, 8'h47, SEP_CHAR,
                  dig(a[11:8]), dig(a[7:4]), dig(a[3:0])};
    l[119:0]   = {15{PAD_CHAR}};
    return l;
  endfunction

  assign vel_adj = add3_vel(vel_bcd);
  assign ang_adj = add3_ang(ang_bcd);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      line_valid  <= 1'b0;
      output_line <= {32{PAD_CHAR}};
      bit_cnt     <= 5'd0;
      vel_bin     <= 17'd0;
      vel_bcd     <= 20'd0;
      ang_bin     <= 10'd0;
      ang_bcd     <= 12'd0;
    end else begin
      line_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vel_bin <= sat_vel(velocity);
            ang_bin <= sat_ang(angle);
            vel_bcd <= 20'd0;
            ang_bcd <= 12'd0;
            bit_cnt <= 5'd0;
            busy    <= 1'b1;
            state   <= CONV_V;
          end
        end
        // 17 shift steps for the 5-digit velocity
        CONV_V: begin
          vel_bcd <= {vel_adj[18:0], vel_bin[16]};
          vel_bin <= {vel_bin[15:0], 1'b0};
          if (bit_cnt == 5'd16) begin
            bit_cnt <= 5'd0;
            state   <= CONV_A;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        // 10 shift steps for the 3-digit angle
        CONV_A: begin
          ang_bcd <= {ang_adj[10:0], ang_bin[9]};
          ang_bin <= {ang_bin[8:0], 1'b0};
          if (bit_cnt == 5'd9) begin
            bit_cnt <= 5'd0;
            state   <= ASSEMBLE;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ASSEMBLE: begin
          output_line <= build_line(vel_bcd, ang_bcd);
          line_valid  <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
